// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus: instruction-memory port, decode handshake,
// redirect input and status outputs.
interface ifetch_unit_if #(
  parameter int CNT_W = 32
);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [31:0]      instr_pc;
  logic             instr_ready;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             misaligned;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready,
    input  redirect,
    input  redirect_pc,
    output misaligned,
    output fetch_count
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready,
    output redirect,
    output redirect_pc,
    input  misaligned,
    input  fetch_count
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: single-outstanding imem requests,
// one instruction at a time to decode, redirect with in-flight kill.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e           state_q;
  logic [31:0]      pc_q;
  logic             kill_q;
  logic             vld_q;
  logic [31:0]      instr_q;
  logic [31:0]      ipc_q;
  logic             mis_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      tgt_d;
  logic [CNT_W-1:0] cnt_d;

  assign tgt_d = {bus.redirect_pc[31:2], 2'b00};
  assign cnt_d = cnt_q + CNT_W'(1);

  // a redirect in FETCH suppresses the request to the stale pc
  assign bus.imem_req  = (state_q == FETCH) && !bus.redirect;
  assign bus.imem_addr = pc_q;

  assign bus.instr_valid = vld_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.misaligned  = mis_q;
  assign bus.fetch_count = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      vld_q   <= 1'b0;
      instr_q <= NOP;
      ipc_q   <= 32'h0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mis_q <= bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
      unique case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (bus.redirect) pc_q <= tgt_d;
          else state_q <= WAIT;
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            if (kill_q || bus.redirect) begin
              kill_q  <= 1'b0;
              state_q <= FETCH;
              if (bus.redirect) pc_q <= tgt_d;
            end else begin
              instr_q <= bus.imem_rdata;
              ipc_q   <= pc_q;
              pc_q    <= pc_q + 32'd4;
              vld_q   <= 1'b1;
              state_q <= HOLD;
            end
          end else if (bus.redirect) begin
            // response still owed; drop it when it lands
            pc_q   <= tgt_d;
            kill_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.instr_ready) cnt_q <= cnt_d;
          if (bus.redirect) begin
            vld_q   <= 1'b0;
            pc_q    <= tgt_d;
            state_q <= FETCH;
          end else if (bus.instr_ready) begin
            vld_q   <= 1'b0;
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios then random traffic,
// checked against a transaction-level fetch-stream model.
module tb_ifetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          CW  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_unit_if #(.CNT_W(CW)) bus ();

  ifetch_unit #(
    .RESET_PC(RPC),
    .CNT_W   (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_dlv    = 0;

  // memory responder state
  logic        pend = 1'b0;
  int          cntdn = 0;
  logic [31:0] paddr = '0;
  int          lat = 1;
  bit          rnd_lat = 1'b0;
  bit          fixed_data = 1'b1;

  // reference: next address the fetch stream must use
  logic [31:0] nxt = RPC;
  logic [31:0] m_cnt = '0;
  logic        saw_req = 1'b0;
  logic [31:0] last_req = '0;
  logic [31:0] req_addrs[$];
  int          req_cycs[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (fixed_data) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: called at negedge with inputs already set
  task automatic cycle();
    logic        acc, p_valid, p_rdy, p_red;
    logic [31:0] p_tgt, p_instr, p_pc;
    #1;
    bus.imem_rvalid = 1'b0;
    if (pend) begin
      cntdn--;
      if (cntdn == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem(paddr);
        pend = 1'b0;
      end
    end
    saw_req = bus.imem_req;
    if (rst_n) begin
      chk("req_during_redirect",
          {31'b0, bus.imem_req && bus.redirect}, 32'd0);
      if (bus.imem_req) begin
        chk("req_addr", bus.imem_addr, nxt);
        chk("outstanding", {31'b0, pend}, 32'd0);
      end
    end
    if (bus.imem_req) begin
      pend  = 1'b1;
      paddr = bus.imem_addr;
      cntdn = rnd_lat ? int'($urandom_range(1, 3)) : lat;
      last_req = bus.imem_addr;
      req_addrs.push_back(bus.imem_addr);
      req_cycs.push_back(cyc);
    end
    acc     = bus.instr_valid && bus.instr_ready;
    p_valid = bus.instr_valid;
    p_rdy   = bus.instr_ready;
    p_red   = bus.redirect && rst_n;
    p_tgt   = bus.redirect_pc;
    p_instr = bus.instr;
    p_pc    = bus.instr_pc;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (acc) m_cnt++;
      if (p_red) nxt = {p_tgt[31:2], 2'b00};
      chk("fetch_count", bus.fetch_count, m_cnt);
      chk("misaligned", {31'b0, bus.misaligned},
          {31'b0, p_red && (p_tgt[1:0] != 2'b00)});
      if (p_valid && !p_rdy && !p_red) begin
        chk("hold_valid", {31'b0, bus.instr_valid}, 32'd1);
        chk("hold_instr", bus.instr, p_instr);
        chk("hold_pc", bus.instr_pc, p_pc);
      end
      if (bus.instr_valid && !p_valid) begin
        chk("dlv_pc", bus.instr_pc, nxt);
        chk("dlv_instr", bus.instr, mem(bus.instr_pc));
        nxt = bus.instr_pc + 32'd4;
        n_dlv++;
      end
    end
  endtask

  task automatic run_until_req(input int max);
    for (int i = 0; i < max; i++) begin
      cycle();
      if (saw_req) break;
    end
    chk("req_timeout", {31'b0, saw_req}, 32'd1);
  endtask

  task automatic run_until_valid(input int max);
    for (int i = 0; i < max; i++) begin
      if (bus.instr_valid) break;
      cycle();
    end
    chk("valid_timeout", {31'b0, bus.instr_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] s_instr, s_pc, s_cnt, r;
    int c0, d0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'h0000_0013);
    chk("rst_pc", bus.instr_pc, 32'd0);
    chk("rst_cnt", bus.fetch_count, 32'd0);
    chk("rst_mis", {31'b0, bus.misaligned}, 32'd0);

    // streaming with ready high and 1-cycle memory
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    c0 = cyc;
    repeat (10) cycle();
    chk("n_reqs_ge3", {31'b0, req_addrs.size() >= 3}, 32'd1);
    if (req_addrs.size() >= 3) begin
      chk("first_req_cyc", req_cycs[0] - c0, 32'd1);
      chk("addr0", req_addrs[0], 32'h0);
      chk("addr1", req_addrs[1], 32'h4);
      chk("addr2", req_addrs[2], 32'h8);
      chk("period01", req_cycs[1] - req_cycs[0], 32'd3);
      chk("period12", req_cycs[2] - req_cycs[1], 32'd3);
    end

    // back-pressure
    bus.instr_ready = 1'b0;
    run_until_valid(20);
    s_instr = bus.instr;
    s_pc    = bus.instr_pc;
    s_cnt   = bus.fetch_count;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_noreq", {31'b0, saw_req}, 32'd0);
    end
    chk("bp_instr", bus.instr, s_instr);
    chk("bp_pc", bus.instr_pc, s_pc);
    chk("bp_cnt", bus.fetch_count, s_cnt);
    bus.instr_ready = 1'b1;
    lat = 3;
    cycle();
    chk("bp_cnt_inc", bus.fetch_count, s_cnt + 32'd1);
    run_until_req(10);
    chk("bp_next_addr", last_req, s_pc + 32'd4);

    // redirect in WAIT, response two cycles later
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    cycle();
    bus.redirect = 1'b0;
    lat = 1;
    chk("w_valid0", {31'b0, bus.instr_valid}, 32'd0);
    cycle();
    chk("w_valid1", {31'b0, bus.instr_valid}, 32'd0);
    cycle();
    chk("w_valid2", {31'b0, bus.instr_valid}, 32'd0);
    run_until_req(10);
    chk("w_addr", last_req, 32'h100);
    run_until_valid(10);
    chk("w_pc", bus.instr_pc, 32'h100);

    // redirect in HOLD to misaligned target with ready high
    s_cnt = bus.fetch_count;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h202;
    cycle();
    bus.redirect = 1'b0;
    chk("h_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("h_cnt", bus.fetch_count, s_cnt + 32'd1);
    chk("h_mis", {31'b0, bus.misaligned}, 32'd1);
    run_until_req(5);
    chk("h_mis_clr", {31'b0, bus.misaligned}, 32'd0);
    chk("h_addr", last_req, 32'h200);

    // redirect coincident with the response in WAIT
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    cycle();
    bus.redirect = 1'b0;
    chk("c_valid", {31'b0, bus.instr_valid}, 32'd0);
    run_until_req(10);
    chk("c_addr", last_req, 32'h300);

    // redirect in FETCH
    bus.instr_ready = 1'b0;
    run_until_valid(10);
    bus.instr_ready = 1'b1;
    cycle();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h400;
    cycle();
    chk("f_noreq", {31'b0, saw_req}, 32'd0);
    bus.redirect = 1'b0;
    lat = 3;
    cycle();
    chk("f_req", {31'b0, saw_req}, 32'd1);
    chk("f_addr", last_req, 32'h400);

    // async reset while waiting on memory
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", {31'b0, bus.imem_req}, 32'd0);
    chk("ar_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("ar_cnt", bus.fetch_count, 32'd0);
    m_cnt = '0;
    nxt   = RPC;
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    lat = 1;
    cycle();
    chk("ar_late_ign", {31'b0, bus.instr_valid}, 32'd0);
    run_until_req(3);
    chk("ar_addr", last_req, RPC);

    // random traffic
    fixed_data = 1'b0;
    rnd_lat    = 1'b1;
    d0 = n_dlv;
    for (int i = 0; i < 600; i++) begin
      bus.instr_ready = ($urandom % 4) != 0;
      bus.redirect    = ($urandom % 8) == 0;
      r = $urandom;
      if (($urandom % 6) == 0) r = {28'hFFF_FFFF, r[3:0]};
      bus.redirect_pc = r;
      cycle();
    end
    bus.redirect = 1'b0;
    chk("rand_progress", {31'b0, (n_dlv - d0) > 20}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
